// File: rtl/menu_select_if.sv
// Pixel stream, button and menu status signals between the menu background
// stage, the selection overlay and the game controller.
interface menu_select_if;
   logic [10:0] hcount_in,  vcount_in;
   logic        hsync_in,   vsync_in,  hblnk_in,  vblnk_in;
   logic [11:0] rgb_in;
   logic        btn_up,     btn_down,  btn_enter;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out,  vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;
   logic [1:0]  sel;
   logic        start_game;
   logic        menu_active;

   modport slave (
      input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
      input  btn_up, btn_down, btn_enter,
      output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
      output sel, start_game, menu_active
   );

   modport master (
      output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
      output btn_up, btn_down, btn_enter,
      input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
      input  sel, start_game, menu_active
   );
endinterface

// File: rtl/menu_select.sv
// Menu item selection: button-driven cursor applied once per frame, plus a
// highlight frame drawn around the selected item on the delayed pixel stream.
module menu_select #(
   parameter int unsigned BORDER   = 4,
   parameter logic [11:0] HL_COLOR = 12'hfff
) (
   input logic           clk,
   input logic           rst,
   menu_select_if.slave  bus
);
   typedef enum logic [1:0] {MENU, CONFIRM, DONE} state_t;

   localparam logic [10:0] X_L = 11'd411;
   localparam logic [10:0] X_R = 11'd610;
   localparam logic [10:0] B   = 11'(BORDER);

   state_t      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic        pend_up_q, pend_up_d, pend_down_q, pend_down_d;
   logic        start_q, start_d;
   logic        vblnk_prev_q;
   // Button vectors: bit 0 up, bit 1 down, bit 2 enter.
   logic [2:0]  sync1_q, sync2_q, prev_q, press_q;
   logic        boundary;

   logic [10:0] hcount_q, vcount_q;
   logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
   logic [11:0] rgb_q;

   logic [10:0] top, bot;
   logic        in_item, on_edge, hl;

   assign boundary = bus.vblnk_in & ~vblnk_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= MENU;
         sel_q        <= '0;
         pend_up_q    <= 1'b0;
         pend_down_q  <= 1'b0;
         start_q      <= 1'b0;
         vblnk_prev_q <= 1'b0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         prev_q       <= '0;
         press_q      <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         pend_up_q    <= pend_up_d;
         pend_down_q  <= pend_down_d;
         start_q      <= start_d;
         vblnk_prev_q <= bus.vblnk_in;
         sync1_q      <= {bus.btn_enter, bus.btn_down, bus.btn_up};
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         press_q      <= sync2_q & ~prev_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      pend_up_d   = pend_up_q;
      pend_down_d = pend_down_q;
      start_d     = 1'b0;
      case (state_q)
         MENU: begin
            if (boundary) begin
               if (pend_up_q && !pend_down_q)
                  sel_d = (sel_q == 2'd0) ? 2'd2 : sel_q - 2'd1;
               else if (pend_down_q && !pend_up_q)
                  sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
               pend_up_d   = 1'b0;
               pend_down_d = 1'b0;
            end
            // Enter overrides any same-cycle move; boundary move above still lands.
            if (press_q[2]) begin
               state_d     = CONFIRM;
               pend_up_d   = 1'b0;
               pend_down_d = 1'b0;
            end else begin
               if (press_q[0]) pend_up_d   = 1'b1;
               if (press_q[1]) pend_down_d = 1'b1;
            end
         end
         CONFIRM: begin
            if (boundary) begin
               state_d = DONE;
               start_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      case (sel_q)
         2'd0:    top = 11'd84;
         2'd1:    top = 11'd180;
         default: top = 11'd276;
      endcase
      bot     = top + 11'd95;
      in_item = (bus.hcount_in >= X_L) && (bus.hcount_in <= X_R) &&
                (bus.vcount_in >= top) && (bus.vcount_in <= bot);
      on_edge = (bus.hcount_in < X_L + B) || (bus.hcount_in > X_R - B) ||
                (bus.vcount_in < top + B) || (bus.vcount_in > bot - B);
      hl      = (state_q != DONE) && !(bus.hblnk_in || bus.vblnk_in) && in_item && on_edge;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_q <= '0;
         vcount_q <= '0;
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         hblnk_q  <= 1'b0;
         vblnk_q  <= 1'b0;
         rgb_q    <= '0;
      end else begin
         hcount_q <= bus.hcount_in;
         vcount_q <= bus.vcount_in;
         hsync_q  <= bus.hsync_in;
         vsync_q  <= bus.vsync_in;
         hblnk_q  <= bus.hblnk_in;
         vblnk_q  <= bus.vblnk_in;
         rgb_q    <= hl ? HL_COLOR : bus.rgb_in;
      end
   end

   assign bus.hcount_out  = hcount_q;
   assign bus.vcount_out  = vcount_q;
   assign bus.hsync_out   = hsync_q;
   assign bus.vsync_out   = vsync_q;
   assign bus.hblnk_out   = hblnk_q;
   assign bus.vblnk_out   = vblnk_q;
   assign bus.rgb_out     = rgb_q;
   assign bus.sel         = sel_q;
   assign bus.start_game  = start_q;
   assign bus.menu_active = (state_q == MENU);
endmodule

// File: tb/tb_menu_select.sv
// Directed bench for menu_select: pixel overlay, cursor moves per frame,
// confirmation pulse and reset behaviour.
module tb_menu_select;
   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   menu_select_if ifc ();

   menu_select #(.BORDER(4), .HL_COLOR(12'hfff)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic frame();
      ifc.vblnk_in = 1'b1;
      tick();
      ifc.vblnk_in = 1'b0;
      tick();
   endtask

   // 0 up, 1 down, 2 enter
   task automatic press(input int b);
      if (b == 0) ifc.btn_up = 1'b1;
      if (b == 1) ifc.btn_down = 1'b1;
      if (b == 2) ifc.btn_enter = 1'b1;
      tick(5);
      ifc.btn_up = 1'b0; ifc.btn_down = 1'b0; ifc.btn_enter = 1'b0;
      tick(5);
   endtask

   task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] c);
      ifc.hcount_in = h; ifc.vcount_in = v; ifc.rgb_in = c;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ifc.hcount_in = 11'd5; ifc.vcount_in = 11'd7;
      ifc.hsync_in = 1'b1; ifc.vsync_in = 1'b1; ifc.hblnk_in = 1'b0; ifc.vblnk_in = 1'b0;
      ifc.rgb_in = 12'habc;
      ifc.btn_up = 1'b0; ifc.btn_down = 1'b0; ifc.btn_enter = 1'b0;
      tick(2);
      chk("rst_hcount", 32'(ifc.hcount_out), 32'd0);
      chk("rst_hsync", 32'(ifc.hsync_out), 32'd0);
      chk("rst_rgb", 32'(ifc.rgb_out), 32'h000);
      chk("rst_sel", 32'(ifc.sel), 32'd0);
      chk("rst_start", 32'(ifc.start_game), 32'd0);
      chk("rst_active", 32'(ifc.menu_active), 32'd1);
      rst = 1'b0;
      ifc.vsync_in = 1'b0;

      // Pixel path
      pix(11'd411, 11'd84, 12'hf52);
      chk("px_corner", 32'(ifc.rgb_out), 32'hfff);
      chk("px_hcount", 32'(ifc.hcount_out), 32'd411);
      chk("px_vcount", 32'(ifc.vcount_out), 32'd84);
      chk("px_hsync", 32'(ifc.hsync_out), 32'd1);
      chk("px_vsync", 32'(ifc.vsync_out), 32'd0);
      pix(11'd430, 11'd120, 12'hf52);
      chk("px_inner", 32'(ifc.rgb_out), 32'hf52);
      pix(11'd414, 11'd120, 12'hf52);
      chk("px_left_b3", 32'(ifc.rgb_out), 32'hfff);
      pix(11'd415, 11'd120, 12'hf52);
      chk("px_left_b4", 32'(ifc.rgb_out), 32'hf52);
      pix(11'd607, 11'd120, 12'hf52);
      chk("px_right_b", 32'(ifc.rgb_out), 32'hfff);
      pix(11'd611, 11'd84, 12'hf52);
      chk("px_outside_x", 32'(ifc.rgb_out), 32'hf52);
      pix(11'd500, 11'd179, 12'hf52);
      chk("px_bottom", 32'(ifc.rgb_out), 32'hfff);
      pix(11'd500, 11'd180, 12'hf52);
      chk("px_other_item", 32'(ifc.rgb_out), 32'hf52);
      ifc.hblnk_in = 1'b1;
      pix(11'd411, 11'd84, 12'h000);
      chk("px_blank_rgb", 32'(ifc.rgb_out), 32'h000);
      chk("px_blank_out", 32'(ifc.hblnk_out), 32'd1);
      ifc.hblnk_in = 1'b0;

      // Wrap up 0 -> 2, then no further change
      press(0);
      chk("up_before_bnd", 32'(ifc.sel), 32'd0);
      frame();
      chk("wrap_up", 32'(ifc.sel), 32'd2);
      frame();
      chk("wrap_2nd_bnd", 32'(ifc.sel), 32'd2);
      pix(11'd411, 11'd276, 12'h0f0);
      chk("px_item2", 32'(ifc.rgb_out), 32'hfff);
      press(1);
      frame();
      chk("wrap_down", 32'(ifc.sel), 32'd0);

      // Up and down in one frame cancel
      press(0);
      press(1);
      frame();
      chk("both_flags", 32'(ifc.sel), 32'd0);
      frame();
      chk("both_cleared", 32'(ifc.sel), 32'd0);

      // Held down across 3 frames
      press(1);
      frame();
      chk("down_to_1", 32'(ifc.sel), 32'd1);
      ifc.btn_down = 1'b1;
      tick(5);
      frame();
      chk("hold_f1", 32'(ifc.sel), 32'd2);
      frame();
      frame();
      chk("hold_f3", 32'(ifc.sel), 32'd2);
      ifc.btn_down = 1'b0;
      tick(5);
      frame();
      chk("hold_release", 32'(ifc.sel), 32'd2);

      // Press landing on the boundary cycle stays pending
      press(0);
      frame();
      chk("back_to_1", 32'(ifc.sel), 32'd1);
      ifc.btn_down = 1'b1;
      tick(3);
      ifc.vblnk_in = 1'b1;
      tick();
      chk("bnd_press_held", 32'(ifc.sel), 32'd1);
      ifc.vblnk_in = 1'b0;
      ifc.btn_down = 1'b0;
      tick(3);
      frame();
      chk("bnd_press_next", 32'(ifc.sel), 32'd2);
      press(0);
      frame();
      chk("sel_1_again", 32'(ifc.sel), 32'd1);

      // Confirm at sel=1
      ifc.btn_enter = 1'b1;
      tick(3);
      chk("enter_3clk", 32'(ifc.menu_active), 32'd1);
      tick();
      chk("enter_4clk", 32'(ifc.menu_active), 32'd0);
      ifc.btn_enter = 1'b0;
      tick(2);
      pix(11'd411, 11'd180, 12'hf52);
      chk("confirm_hl", 32'(ifc.rgb_out), 32'hfff);
      press(0);
      chk("confirm_ignore", 32'(ifc.sel), 32'd1);
      chk("confirm_nostart", 32'(ifc.start_game), 32'd0);
      ifc.vblnk_in = 1'b1;
      tick();
      chk("start_pulse", 32'(ifc.start_game), 32'd1);
      tick();
      chk("start_1cycle", 32'(ifc.start_game), 32'd0);
      ifc.vblnk_in = 1'b0;
      pix(11'd411, 11'd180, 12'hf52);
      chk("done_no_hl", 32'(ifc.rgb_out), 32'hf52);
      chk("done_sel", 32'(ifc.sel), 32'd1);
      chk("done_inactive", 32'(ifc.menu_active), 32'd0);
      press(1);
      ifc.vblnk_in = 1'b1;
      tick();
      chk("done_no_start", 32'(ifc.start_game), 32'd0);
      ifc.vblnk_in = 1'b0;
      tick();
      chk("done_sel_hold", 32'(ifc.sel), 32'd1);

      // Enter on a boundary with a pending move
      rst = 1'b1;
      tick();
      chk("rst2_sel", 32'(ifc.sel), 32'd0);
      chk("rst2_active", 32'(ifc.menu_active), 32'd1);
      rst = 1'b0;
      tick();
      press(1);
      ifc.btn_enter = 1'b1;
      tick(3);
      ifc.vblnk_in = 1'b1;
      tick();
      chk("bnd_enter_sel", 32'(ifc.sel), 32'd1);
      chk("bnd_enter_active", 32'(ifc.menu_active), 32'd0);
      chk("bnd_enter_nostart", 32'(ifc.start_game), 32'd0);
      tick();
      chk("bnd_enter_nostart2", 32'(ifc.start_game), 32'd0);
      ifc.vblnk_in = 1'b0;
      ifc.btn_enter = 1'b0;
      tick(3);
      ifc.vblnk_in = 1'b1;
      tick();
      chk("bnd_enter_start", 32'(ifc.start_game), 32'd1);
      chk("bnd_enter_sel2", 32'(ifc.sel), 32'd1);
      ifc.vblnk_in = 1'b0;
      tick();

      // Enter with up in the same cycle, then reset mid-CONFIRM
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      ifc.btn_up = 1'b1;
      ifc.btn_enter = 1'b1;
      tick(5);
      ifc.btn_up = 1'b0;
      ifc.btn_enter = 1'b0;
      tick(3);
      chk("up_enter_active", 32'(ifc.menu_active), 32'd0);
      chk("up_enter_sel", 32'(ifc.sel), 32'd0);
      rst = 1'b1;
      ifc.vblnk_in = 1'b1;
      tick();
      chk("rstc_start", 32'(ifc.start_game), 32'd0);
      chk("rstc_active", 32'(ifc.menu_active), 32'd1);
      chk("rstc_rgb", 32'(ifc.rgb_out), 32'h000);
      chk("rstc_vblnk", 32'(ifc.vblnk_out), 32'd0);
      ifc.vblnk_in = 1'b0;
      tick(2);
      rst = 1'b0;
      frame();
      chk("rstc_after_start", 32'(ifc.start_game), 32'd0);
      chk("rstc_after_sel", 32'(ifc.sel), 32'd0);
      chk("rstc_after_active", 32'(ifc.menu_active), 32'd1);
      pix(11'd411, 11'd84, 12'h123);
      chk("rstc_hl_back", 32'(ifc.rgb_out), 32'hfff);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/menu_select.md
MENU_SELECT -- requirements
Module: menu_select

Interface
REQ-001 Parameter: BORDER, default 4, highlight frame thickness in pixels.
REQ-002 Parameter: HL_COLOR, default 12'hfff, highlight frame colour.
REQ-003 clk  in  1  pixel clock; all logic on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 hcount_in, vcount_in  in  11 each  pixel position from the upstream menu background stage.
REQ-006 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  upstream sync and blanking.
REQ-007 rgb_in  in  12  upstream pixel colour.
REQ-008 btn_up, btn_down, btn_enter  in  1 each  debounced but asynchronous button levels.
REQ-009 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  same widths as inputs  delayed stream with overlay.
REQ-010 sel  out  2  current menu item index, 0..2.
REQ-011 start_game  out  1  single-cycle pulse on confirmation.
REQ-012 menu_active  out  1  high while the selection is still changeable.

Function
REQ-013 Pixel path SHALL have exactly 1 clk of latency; all seven stream outputs SHALL be registered together.
REQ-014 Sync, blank and count signals SHALL pass through unchanged.
REQ-015 Menu geometry: x 411..610, three items of 96 rows each at y 84+96*i .. 179+96*i, for i = 0..2.
REQ-016 rgb_out SHALL be HL_COLOR when all of the following hold: state is MENU or CONFIRM; not blanking; pixel is inside item sel; pixel is within BORDER pixels of that item's edge.
REQ-017 Otherwise rgb_out SHALL equal rgb_in, including 12'h000 during blanking.
REQ-018 Each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-019 A press SHALL register on the cycle after synchronizer stage 2 first goes high (3 clk after the input rises).
REQ-020 A held button SHALL produce only one press.
REQ-021 Up and down presses SHALL set sticky flags pend_up / pend_down.
REQ-022 Frame boundary = rising edge of vblnk_in (vblnk_in high, previous value low).
REQ-023 In MENU at a frame boundary:
- pend_up only: sel = sel-1, with 0 wrapping to 2.
- pend_down only: sel = sel+1, with 2 wrapping to 0.
- both flags set: sel unchanged.
- in all three cases, both flags are cleared on that cycle.
REQ-024 A press arriving on the boundary cycle itself SHALL stay pending for the next frame.
REQ-025 FSM states: MENU, CONFIRM, DONE.
REQ-026 MENU -> CONFIRM on an enter press. On that transition pend_up and pend_down SHALL be cleared and sel SHALL freeze.
REQ-027 CONFIRM -> DONE at the next frame boundary. start_game SHALL be high for exactly that one cycle.
REQ-028 In CONFIRM and DONE, all button presses SHALL be ignored.
REQ-029 In DONE the highlight SHALL be off and sel SHALL hold its value.
REQ-030 DONE SHALL be left only by rst.
REQ-031 menu_active SHALL be high in MENU and low in CONFIRM and DONE.
REQ-032 An enter press and an up/down press on the same cycle: enter wins and the move is discarded.
REQ-033 An enter press on a frame-boundary cycle: pending moves are applied first, then the FSM enters CONFIRM. start_game fires on the following boundary, not the current one.

Reset
REQ-034 While rst is high, all of the following SHALL be 0: stream outputs, rgb_out, sel, start_game, synchronizer flops, edge-detect flops, pend flags and the vblnk history flop.
REQ-035 While rst is high, menu_active SHALL be 1 and the state SHALL be MENU.
REQ-036 Reset asserted mid-CONFIRM SHALL suppress start_game; after release the FSM SHALL restart in MENU with sel = 0.

Verification
REQ-037 Pixel path: hcount_in=411, vcount_in=84, sel=0, rgb_in=12'h f52 -> next cycle rgb_out=12'hfff. At (430,120): rgb_out=12'hf52.
REQ-038 Wrap: sel=0, pulse btn_up for 5 clk, then a vblnk rise -> sel=2; pend flags cleared; sel unchanged at the second boundary.
REQ-039 Simultaneous: btn_up and btn_down both pressed within one frame -> sel unchanged at the boundary.
REQ-040 Hold: btn_down held for 3 frames from sel=1 -> sel=2 after frame 1, still 2 after frame 3.
REQ-041 Confirm: sel=1, press btn_enter -> menu_active falls 4 clk after the input rises. start_game is a 1-cycle pulse on the next vblnk rise; highlight absent in the following frame; sel stays 1.
REQ-042 Reset mid-CONFIRM: assert rst before the boundary -> no start_game pulse, all outputs 0, menu_active=1.
